// File: rtl/dac_serial_multi.sv
// Dual-channel serial DAC driver: two samples shifted out MSB-first on a shared chip select and serial clock.
// Define DAC_SERIAL_HOLD_BUFFER_EN to add a one-deep sample holding register for requests that arrive while busy.
module dac_serial_multi #(
  parameter int DATA_WIDTH  = 12,
  parameter int FRAME_WIDTH = 16,
  parameter int CLK_DIV     = 2,
  parameter int QUIET_TICKS = 2
) (
  input  logic                  inClk,
  input  logic                  inReset_n,
  input  logic [DATA_WIDTH-1:0] inSampleA,
  input  logic [DATA_WIDTH-1:0] inSampleB,
  input  logic                  inSampleReady,
  input  logic                  inClearOverrun,
  output logic                  outChipSelect,
  output logic                  outSerialClk,
  output logic                  outDataA,
  output logic                  outDataB,
  output logic                  outBusy,
  output logic                  outOverrun
);

  localparam int DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BitW   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int QuietW = (QUIET_TICKS > 1) ? $clog2(QUIET_TICKS) : 1;
  localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]   BitLast   = BitW'(FRAME_WIDTH - 1);
  localparam logic [QuietW-1:0] QuietLast = QuietW'(QUIET_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [DivW-1:0]        divCnt;
  logic [BitW-1:0]        bitCnt;
  logic [QuietW-1:0]      quietCnt;
  logic [FRAME_WIDTH-1:0] shiftA;
  logic [FRAME_WIDTH-1:0] shiftB;
  logic                   sclk;
  logic                   readyQ;
  logic                   edgeArmed;
  logic                   overrun;
  logic                   tick;
  logic                   reqEdge;
  logic                   startFrame;
  logic                   lostSample;
  logic                   holdValid;
  logic [DATA_WIDTH-1:0]  srcA;
  logic [DATA_WIDTH-1:0]  srcB;

  assign tick    = (divCnt == DivLast);
  assign reqEdge = edgeArmed & inSampleReady & ~readyQ;

  // Edge detection only arms one cycle after reset release, so a level held through reset is not a request
  always_ff @(posedge inClk or negedge inReset_n) begin
    if (!inReset_n) begin
      readyQ    <= 1'b0;
      edgeArmed <= 1'b0;
    end else begin
      readyQ    <= inSampleReady;
      edgeArmed <= 1'b1;
    end
  end

`ifdef DAC_SERIAL_HOLD_BUFFER_EN
  logic [DATA_WIDTH-1:0] holdA;
  logic [DATA_WIDTH-1:0] holdB;
  logic                  loadHold;

  // A held sample being consumed in IDLE frees the register for a coincident new request
  assign loadHold   = reqEdge & ((state != IDLE) | holdValid);
  assign lostSample = reqEdge & (state != IDLE) & holdValid;
  assign srcA       = holdValid ? holdA : inSampleA;
  assign srcB       = holdValid ? holdB : inSampleB;

  always_ff @(posedge inClk or negedge inReset_n) begin
    if (!inReset_n) begin
      holdValid <= 1'b0;
      holdA     <= '0;
      holdB     <= '0;
    end else if (loadHold) begin
      holdValid <= 1'b1;
      holdA     <= inSampleA;
      holdB     <= inSampleB;
    end else if (state == IDLE) begin
      holdValid <= 1'b0;
    end
  end
`else
  assign holdValid  = 1'b0;
  assign lostSample = reqEdge & (state != IDLE);
  assign srcA       = inSampleA;
  assign srcB       = inSampleB;
`endif

  always_ff @(posedge inClk or negedge inReset_n) begin
    if (!inReset_n) state <= IDLE;
    else            state <= stateNext;
  end

  // Next state plus chip select and data; data is only driven while the frame is in SHIFT
  always_comb begin
    stateNext     = state;
    startFrame    = 1'b0;
    outChipSelect = 1'b1;
    outDataA      = 1'b0;
    outDataB      = 1'b0;
    case (state)
      IDLE: begin
        if (reqEdge || holdValid) begin
          startFrame = 1'b1;
          stateNext  = SHIFT;
        end
      end
      SHIFT: begin
        outChipSelect = 1'b0;
        outDataA      = shiftA[FRAME_WIDTH-1];
        outDataB      = shiftB[FRAME_WIDTH-1];
        if (tick && !sclk && (bitCnt == BitLast)) stateNext = QUIET;
      end
      QUIET: begin
        if (tick && (quietCnt == QuietLast)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Serial clock starts high, so each rising toggle closes one bit and shifts in the next
  always_ff @(posedge inClk or negedge inReset_n) begin
    if (!inReset_n) begin
      divCnt   <= '0;
      bitCnt   <= '0;
      quietCnt <= '0;
      sclk     <= 1'b1;
      shiftA   <= '0;
      shiftB   <= '0;
    end else begin
      case (state)
        IDLE: begin
          divCnt   <= '0;
          bitCnt   <= '0;
          quietCnt <= '0;
          sclk     <= 1'b1;
          if (startFrame) begin
            shiftA <= FRAME_WIDTH'(srcA);
            shiftB <= FRAME_WIDTH'(srcB);
          end
        end
        SHIFT: begin
          if (tick) begin
            divCnt <= '0;
            sclk   <= ~sclk;
            if (!sclk && (bitCnt != BitLast)) begin
              bitCnt <= bitCnt + 1'b1;
              shiftA <= shiftA << 1;
              shiftB <= shiftB << 1;
            end
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        QUIET: begin
          if (tick) begin
            divCnt <= '0;
            if (quietCnt != QuietLast) quietCnt <= quietCnt + 1'b1;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        default: begin
          divCnt <= '0;
          sclk   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge inClk or negedge inReset_n) begin
    if (!inReset_n)          overrun <= 1'b0;
    else if (lostSample)     overrun <= 1'b1;
    else if (inClearOverrun) overrun <= 1'b0;
  end

  assign outSerialClk = sclk;
  assign outBusy      = (state != IDLE) | holdValid;
  assign outOverrun   = overrun;

endmodule

// File: doc/dac_serial_multi.md
DAC_SERIAL_MULTI -- requirements
Module: dac_serial_multi

Interface
REQ-001 Parameter DATA_WIDTH, default 12: sample width per channel, legal range 1..FRAME_WIDTH.
REQ-002 Parameter FRAME_WIDTH, default 16: serial bits per conversion frame.
REQ-003 Parameter CLK_DIV, default 2: inClk cycles per serial half-period ("tick"); minimum 1.
REQ-004 Parameter QUIET_TICKS, default 2: ticks with chip-select high between frames; minimum 1.
REQ-005 inClk  input  1  system clock; all state on its rising edge.
REQ-006 inReset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 inSampleA  input  DATA_WIDTH  channel A sample, unsigned.
REQ-008 inSampleB  input  DATA_WIDTH  channel B sample, unsigned.
REQ-009 inSampleReady  input  1  sample strobe; rising edge requests one conversion of both channels.
REQ-010 inClearOverrun  input  1  synchronous clear of outOverrun.
REQ-011 outChipSelect  output  1  DAC chip select, active-low.
REQ-012 outSerialClk  output  1  serial clock to DAC; idles high.
REQ-013 outDataA / outDataB  output  1 each  serial data, channel A / B, MSB first.
REQ-014 outBusy  output  1  high while a frame is in progress or a sample is pending.
REQ-015 outOverrun  output  1  sticky: a sample was lost or overwritten.

Function
REQ-016 Block SHALL detect inSampleReady rising edges (registered previous value); a held-high level SHALL yield exactly one request.
REQ-017 Frame word per channel SHALL be {FRAME_WIDTH-DATA_WIDTH zeros, sample}, captured at request acceptance.
REQ-018 FSM states SHALL be IDLE, SHIFT, QUIET.
REQ-019 IDLE: outChipSelect=1, outSerialClk=1, outDataA/B=0; on pending request -> SHIFT next cycle, divider cleared.
REQ-020 Request edge sampled at cycle k in IDLE with nothing pending SHALL give outChipSelect=0 and first MSB on outDataA/B at cycle k+1.
REQ-021 SHIFT: outSerialClk SHALL toggle every tick (CLK_DIV cycles); data SHALL change only on serialClk rising edges, stable across each falling edge.
REQ-022 SHIFT SHALL last exactly 2*FRAME_WIDTH ticks (FRAME_WIDTH falling edges) and end with outSerialClk=1, then -> QUIET.
REQ-023 QUIET: outChipSelect=1, outSerialClk=1 for QUIET_TICKS ticks, then -> IDLE.
REQ-024 Request accepted while IDLE with nothing pending SHALL start a frame; outside IDLE it SHALL follow REQ-033/034.
REQ-025 Request edge in the final QUIET cycle SHALL be treated as arriving while busy.
REQ-026 outBusy SHALL be 1 whenever state != IDLE or a held sample is valid.
REQ-027 outOverrun SHALL set on any lost or overwritten sample; inClearOverrun clears it; simultaneous set and clear -> set wins.
REQ-028 Divider and bit counter SHALL be sized by $clog2 of CLK_DIV and FRAME_WIDTH; no wrap beyond terminal count.

Reset
REQ-029 inReset_n low SHALL immediately force: state IDLE, outChipSelect=1, outSerialClk=1, outDataA/B=0, outBusy=0, outOverrun=0, held sample invalid, edge register 0.
REQ-030 Reset mid-frame SHALL abort the frame with no further serial-clock edges; no partial frame resumes after release.
REQ-031 A high inSampleReady at reset release SHALL NOT count as an edge.

Configuration
REQ-032 Macro DAC_SERIAL_HOLD_BUFFER_EN selects a one-deep holding register.
REQ-033 Defined: request while busy SHALL load the holding register; overwriting a valid held sample SHALL set outOverrun; a valid hold SHALL start a frame on the first IDLE cycle after QUIET (one IDLE cycle between frames).
REQ-034 Undefined: request while busy SHALL be dropped and SHALL set outOverrun; no holding register is synthesised.

Verification
REQ-035 Defaults, A=0xABC, B=0x123, one edge in IDLE -> CS low next cycle; A bits 0000_1010_1011_1100, B bits 0000_0001_0010_0011 on 16 falling edges; frame = 64 cycles; CS high 4 cycles.
REQ-036 inSampleReady held high 200 cycles -> exactly one frame; outOverrun stays 0.
REQ-037 With _EN: edges at cycle 0, 10, 20 -> two frames (first sample, third sample), outOverrun=1; without _EN -> one frame, outOverrun=1.
REQ-038 inReset_n low at cycle 30 of a frame -> CS=1, SCLK=1, data=0 within same cycle; no further SCLK edges after release.
REQ-039 DATA_WIDTH=8, FRAME_WIDTH=10, CLK_DIV=1, A=0xFF -> bits 00_1111_1111, frame 20 cycles.
REQ-040 inClearOverrun pulsed in same cycle as a new overrun -> outOverrun remains 1; pulsed alone -> 0 next cycle.
